dmem_dump: RTL and testbench

DMEM_DUMP -- requirements
Module: dmem_dump

---
 rtl/dmem_dump.sv | 163 ++++++++++++++++
 tb/tb_dmem_dump.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump.sv
// -----------------------------------------------------------------------------
// dmem_dump
//   Streams a contiguous byte range out of an attached data memory, one byte
//   per valid/ready handshake. Each byte costs one read cycle (RD) followed by
//   at least one presentation cycle (OUT). The fastest rate is therefore one
//   byte every two cycles.
//
//   The memory registers mem_rdata on the falling edge from mem_addr. The
//   falling edge inside the RD cycle supplies the byte that is captured at
//   the rising edge closing RD.
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle dump request, only looked at in IDLE
//   start_addr  first byte address of the dump
//   len         number of bytes to dump (0 .. 2**ADDR_W)
//   abort       synchronous cancel of an active dump
//   mem_addr    read address to the memory (held in IDLE)
//   mem_re      read enable, high only in RD
//   mem_rdata   memory read data
//   out_valid   out_data carries a byte
//   out_data    dumped byte
//   out_ready   consumer accepts out_data when out_valid is also high
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle pulse after a dump completes normally
// -----------------------------------------------------------------------------
module dmem_dump #(
    parameter int ADDR_W = 13,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        OUT  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              mem_re_q, mem_re_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has no meaning here and is deliberately ignored
                if (start) begin
                    if (len != '0) begin
                        mem_addr_d  = start_addr;
                        remaining_d = len;
                        state_d     = RD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end

            RD: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_data_d  = mem_rdata;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end

            OUT: begin
                // abort wins over a simultaneous handshake: the byte on the
                // bus is treated as never delivered
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        // wraps naturally at 2**ADDR_W
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        state_d    = RD;
                    end
                end
            end

            FIN: begin
                // done is registered from FIN, so it shows up the cycle after
                // FIN, together with busy dropping
                state_d = IDLE;
                done_d  = ~abort;
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Moore outputs decoded from the next state so they line up with it
        mem_re_d = (state_d == RD);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            mem_re_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            mem_re_q    <= mem_re_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dmem_dump.sv
// -----------------------------------------------------------------------------
// tb_dmem_dump
//   Directed bench for dmem_dump. A memory model preloaded with mem[i]=i[7:0]
//   registers its read data on the falling edge. Expected bytes are queued
//   when a dump is launched and popped whenever a handshake is due at the
//   next rising edge. Inputs are driven and outputs sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_dmem_dump;
    localparam int ADDR_W = 13;
    localparam int LEN_W  = ADDR_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata = '0;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;
    int nbytes = 0;
    int ndone  = 0;
    int nre    = 0;
    int nov    = 0;
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] addr_log[$];

    dmem_dump #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .abort      (abort),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i[7:0];
    end

    always @(negedge clk) mem_rdata <= mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle (handshake due at the coming rising edge),
    // then advance to the next falling edge.
    task automatic step();
        logic [7:0] e;
        if (out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("byte", {24'h0, out_data}, {24'h0, e});
            end
            nbytes++;
        end
        if (mem_re) begin
            addr_log.push_back(mem_addr);
            nre++;
        end
        if (out_valid) nov++;
        if (done) ndone++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input int max_cyc, output int lat);
        lat = 0;
        while (!done && lat < max_cyc) begin
            step();
            lat++;
        end
        chk("done_seen", {31'h0, done}, 32'd1);
    endtask

    task automatic launch(input logic [ADDR_W-1:0] a, input int n);
        logic [ADDR_W-1:0] p;
        p = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[p]);
            p = p + ADDR_W'(1);
        end
        start_addr = a;
        len        = LEN_W'(n);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    initial begin
        int lat;
        int b0, d0, r0, v0, k;
        logic [ADDR_W-1:0] wrap_addr [4];
        wrap_addr[0] = 13'h1FFE;
        wrap_addr[1] = 13'h1FFF;
        wrap_addr[2] = 13'h0000;
        wrap_addr[3] = 13'h0001;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_mem_addr",  {19'h0, mem_addr}, 32'h0);
        chk("rst_mem_re",    {31'h0, mem_re}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data",  {24'h0, out_data}, 32'h0);
        chk("rst_busy",      {31'h0, busy}, 32'h0);
        chk("rst_done",      {31'h0, done}, 32'h0);

        // ---- basic dump 0x010 len 4, start on the first edge after reset ----
        rst = 1'b0;
        launch(13'h010, 4);
        chk("t1_busy",     {31'h0, busy}, 32'd1);
        chk("t1_mem_re",   {31'h0, mem_re}, 32'd1);
        chk("t1_mem_addr", {19'h0, mem_addr}, 32'h010);
        chk("t1_ov_rd",    {31'h0, out_valid}, 32'd0);
        step();
        chk("t1_ov_out",   {31'h0, out_valid}, 32'd1);
        chk("t1_data0",    {24'h0, out_data}, 32'h10);
        chk("t1_re_out",   {31'h0, mem_re}, 32'd0);
        // bytes accepted at edges 2,4,6,8 after the start edge, FIN after 8,
        // done visible after edge 9
        run_until_done(40, lat);
        chk("t1_done_lat", lat, 32'd8);
        chk("t1_busy_at_done", {31'h0, busy}, 32'd0);
        step();
        chk("t1_done_pulse", {31'h0, done}, 32'd0);
        chk("t1_ndone", ndone, 32'd1);
        chk("t1_nbytes", nbytes, 32'd4);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // ---------------- address wrap ----------------
        addr_log.delete();
        b0 = nbytes;
        launch(13'h1FFE, 4);
        run_until_done(40, lat);
        step();
        chk("t2_nbytes", nbytes - b0, 32'd4);
        chk("t2_nreads", addr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size())
                chk("t2_addr", {19'h0, addr_log[i]}, {19'h0, wrap_addr[i]});
        end
        chk("t2_mem_addr_hold", {19'h0, mem_addr}, 32'h0001);

        // ---------------- zero length ----------------
        r0 = nre;
        v0 = nov;
        d0 = ndone;
        launch(13'h100, 0);
        chk("t3_busy", {31'h0, busy}, 32'd1);
        chk("t3_done_early", {31'h0, done}, 32'd0);
        run_until_done(10, lat);
        chk("t3_done_lat", lat, 32'd1);
        step();
        chk("t3_no_read", nre - r0, 32'd0);
        chk("t3_no_valid", nov - v0, 32'd0);
        chk("t3_ndone", ndone - d0, 32'd1);

        // ---------------- back-pressure on the 2nd byte ----------------
        b0 = nbytes;
        launch(13'h010, 3);
        k = 0;
        while (!(out_valid && nbytes == b0 + 1) && k < 20) begin
            step();
            k++;
        end
        chk("t4_reach", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", {31'h0, out_valid}, 32'd1);
            chk("t4_hold_data", {24'h0, out_data}, 32'h11);
            chk("t4_hold_re", {31'h0, mem_re}, 32'd0);
        end
        out_ready = 1'b1;
        run_until_done(40, lat);
        step();
        chk("t4_nbytes", nbytes - b0, 32'd3);
        chk("t4_queue_empty", exp_q.size(), 32'd0);

        // ---------------- abort in OUT of the 3rd byte ----------------
        b0 = nbytes;
        launch(13'h020, 8);
        k = 0;
        while (!(out_valid && nbytes == b0 + 2) && k < 20) begin
            step();
            k++;
        end
        chk("t5_reach", {24'h0, out_data}, 32'h22);
        abort = 1'b1;
        d0 = ndone;
        step();
        abort = 1'b0;
        chk("t5_busy", {31'h0, busy}, 32'd0);
        chk("t5_ov", {31'h0, out_valid}, 32'd0);
        chk("t5_re", {31'h0, mem_re}, 32'd0);
        chk("t5_undelivered", exp_q.size(), 32'd6);
        exp_q.delete();
        repeat (4) step();
        chk("t5_no_done", ndone - d0, 32'd0);
        b0 = nbytes;
        launch(13'h055, 1);
        run_until_done(20, lat);
        step();
        chk("t5_after_nbytes", nbytes - b0, 32'd1);
        chk("t5_after_queue", exp_q.size(), 32'd0);

        // ---------------- asynchronous reset mid-dump ----------------
        d0 = ndone;
        launch(13'h030, 6);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("t6_mem_addr",  {19'h0, mem_addr}, 32'h0);
        chk("t6_mem_re",    {31'h0, mem_re}, 32'h0);
        chk("t6_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_out_data",  {24'h0, out_data}, 32'h0);
        chk("t6_busy",      {31'h0, busy}, 32'h0);
        chk("t6_done",      {31'h0, done}, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        chk("t6_no_done", ndone - d0, 32'd0);

        // ---------------- start while busy is ignored ----------------
        b0 = nbytes;
        d0 = ndone;
        launch(13'h040, 3);
        step();
        start_addr = 13'h080;
        len        = LEN_W'(5);
        start      = 1'b1;
        step();
        start      = 1'b0;
        run_until_done(40, lat);
        step();
        chk("t7_nbytes", nbytes - b0, 32'd3);
        chk("t7_queue_empty", exp_q.size(), 32'd0);
        chk("t7_ndone", ndone - d0, 32'd1);
        repeat (4) step();
        chk("t7_idle", {31'h0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
